ball_engine: RTL and testbench
==============================

Name: ball_engine

Overview:
Parametrised successor to the fixed-size Pong ball mover. Advances the ball once per frame tick with configurable step sizes. Detects wall and paddle collisions using the full ball and paddle extents, and runs a serve/play/point state machine that emits per-player scoring pulses. Sits between the paddle controllers and the video renderer/score keeper.

Parameters:
COORD_W, 9, width of every coordinate bus
MIN_H, 0, leftmost ball x
MAX_H, 320, right playfield edge; ball x never exceeds MAX_H-SIZE
MIN_V, 0, top ball y
MAX_V, 240, bottom playfield edge; ball y never exceeds MAX_V-SIZE
SIZE, 4, ball edge length in pixels
PADDLE_LEN, 32, paddle height in pixels
STEP_H, 1, horizontal pixels moved per tick
STEP_V, 1, vertical pixels moved per tick
SERVE_DELAY, 60, ticks held in POINT before re-centring
START_H, (MAX_H+MIN_H-SIZE)/2, serve x (158 with defaults)
START_V, (MAX_V+MIN_V-SIZE)/2, serve y (118 with defaults)

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-low reset
tick  in  1  one-cycle frame-advance strobe
serve  in  1  start-play request; sampled only in SERVE
player1_paddle  in  COORD_W  top y of left paddle
player2_paddle  in  COORD_W  top y of right paddle
ball_x  out  COORD_W  ball left edge
ball_y  out  COORD_W  ball top edge
dir_h  out  1  1 = moving right
dir_v  out  1  1 = moving down
in_play  out  1  high in PLAY
hit  out  1  one-cycle pulse on a paddle bounce
p1_point  out  1  one-cycle pulse when the ball passes the right edge
p2_point  out  1  one-cycle pulse when the ball passes the left edge

Behaviour:
- Reset (reset=0, async): ball_x=START_H, ball_y=START_V, dir_h=1, dir_v=1, state=SERVE. All pulses 0. Tick counter 0.
- States: SERVE, PLAY, POINT.
- SERVE: ball held at (START_H, START_V). serve=1 at a clock edge moves to PLAY on the next cycle. Ticks are ignored in SERVE.
- PLAY: all updates happen only on a cycle with tick=1. Outputs change the cycle after tick.
- Vertical motion: if dir_v=1 and ball_y+STEP_V >= MAX_V-SIZE, then ball_y=MAX_V-SIZE and dir_v=0. If dir_v=0 and ball_y <= MIN_V+STEP_V, then ball_y=MIN_V and dir_v=1. Otherwise ball_y moves by ±STEP_V.
- Horizontal motion, right side: if dir_h=1 and ball_x+STEP_H >= MAX_H-SIZE, then ball_x=MAX_H-SIZE and the right paddle is checked.
- Horizontal motion, left side: if dir_h=0 and ball_x <= MIN_H+STEP_H, then ball_x=MIN_H and the left paddle is checked.
- Otherwise ball_x moves by ±STEP_H.
- Paddle overlap test uses the updated ball_y: (ball_y+SIZE > paddle) AND (ball_y < paddle+PADDLE_LEN).
- Overlap: dir_h is inverted, hit pulses, state stays PLAY.
- No overlap: p1_point (right miss) or p2_point (left miss) pulses, state goes to POINT, and the ball holds at the edge.
- All edge arithmetic is done in COORD_W+1 bits, so no wrap-around is possible.
- A corner hit reflects both axes on the same tick.
- POINT: counts SERVE_DELAY ticks and ignores serve. On the last tick: ball returns to the start position, dir_h points toward the player who conceded, dir_v is retained, state goes to SERVE.
- Pulses are exactly one clock cycle wide. hit and a point pulse never assert together.
- Asserting reset mid-PLAY or mid-POINT returns immediately to the reset values. No point pulse is generated.
- A tick on the same cycle as the SERVE→PLAY transition does not move the ball.

Decomposition:
- Package pong_pkg holds the state enum {SERVE, PLAY, POINT}, COORD_W default, and the direction encodings DIR_RIGHT=1 and DIR_DOWN=1.
- One sub-module, paddle_overlap (combinational comparator on ball_y, paddle, SIZE, PADDLE_LEN), instantiated twice.

Test Plan:
- Reset -> (158,118), dir_h=1, dir_v=1, in_play=0, pulses 0. Ticks without serve -> no motion.
- serve, then 10 ticks -> ball (168,128), in_play=1.
- 118 ticks after serve -> ball_y=236, dir_v=0, ball_x=276.
- player2_paddle=180, 158 ticks -> ball (316,196), one hit pulse, dir_h=0. Next tick -> ball_x=315.
- player2_paddle=0, 158 ticks -> one p1_point pulse, state POINT. After 60 ticks -> (158,118), SERVE, dir_h=1.
- reset=0 asynchronously mid-PLAY -> outputs return to reset values with no clock edge. No point pulse.

Source files
------------

// File: rtl/pong_pkg.sv
// Shared types and encodings for the Pong ball engine and its helpers.
package pong_pkg;

    localparam int COORD_W_DEFAULT = 9;

    typedef enum logic [1:0] {
        SERVE = 2'd0,
        PLAY  = 2'd1,
        POINT = 2'd2
    } state_t;

    localparam logic DIR_RIGHT = 1'b1;
    localparam logic DIR_DOWN  = 1'b1;

endpackage

// File: rtl/paddle_overlap.sv
// Combinational test of whether the ball's vertical extent overlaps a paddle.
module paddle_overlap #(
    parameter int COORD_W    = 9,
    parameter int SIZE       = 4,
    parameter int PADDLE_LEN = 32
) (
    input  logic [COORD_W-1:0] ball_y,
    input  logic [COORD_W-1:0] paddle,
    output logic               overlap
);
    localparam int W = COORD_W + 1;
    localparam logic [W-1:0] SZ  = W'(SIZE);
    localparam logic [W-1:0] LEN = W'(PADDLE_LEN);

    // one extra bit keeps paddle+LEN from wrapping near the bottom edge
    assign overlap = (({1'b0, ball_y} + SZ) > {1'b0, paddle}) &&
                     ({1'b0, ball_y} < ({1'b0, paddle} + LEN));

endmodule

// File: rtl/ball_engine.sv
// Ball mover: per-tick motion, wall/paddle collisions, serve/play/point sequencing.
module ball_engine
    import pong_pkg::*;
#(
    parameter int COORD_W     = COORD_W_DEFAULT,
    parameter int MIN_H       = 0,
    parameter int MAX_H       = 320,
    parameter int MIN_V       = 0,
    parameter int MAX_V       = 240,
    parameter int SIZE        = 4,
    parameter int PADDLE_LEN  = 32,
    parameter int STEP_H      = 1,
    parameter int STEP_V      = 1,
    parameter int SERVE_DELAY = 60,
    parameter int START_H     = (MAX_H + MIN_H - SIZE) / 2,
    parameter int START_V     = (MAX_V + MIN_V - SIZE) / 2
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               tick,
    input  logic               serve,
    input  logic [COORD_W-1:0] player1_paddle,
    input  logic [COORD_W-1:0] player2_paddle,
    output logic [COORD_W-1:0] ball_x,
    output logic [COORD_W-1:0] ball_y,
    output logic               dir_h,
    output logic               dir_v,
    output logic               in_play,
    output logic               hit,
    output logic               p1_point,
    output logic               p2_point
);
    localparam int W     = COORD_W + 1;
    localparam int CNT_W = $clog2(SERVE_DELAY + 1);

    localparam logic [W-1:0] X_HI_W   = W'(MAX_H - SIZE);
    localparam logic [W-1:0] X_LOE_W  = W'(MIN_H + STEP_H);
    localparam logic [W-1:0] Y_HI_W   = W'(MAX_V - SIZE);
    localparam logic [W-1:0] Y_LOE_W  = W'(MIN_V + STEP_V);
    localparam logic [W-1:0] STH_W    = W'(STEP_H);
    localparam logic [W-1:0] STV_W    = W'(STEP_V);

    localparam logic [COORD_W-1:0] X_HI = COORD_W'(MAX_H - SIZE);
    localparam logic [COORD_W-1:0] X_LO = COORD_W'(MIN_H);
    localparam logic [COORD_W-1:0] Y_HI = COORD_W'(MAX_V - SIZE);
    localparam logic [COORD_W-1:0] Y_LO = COORD_W'(MIN_V);
    localparam logic [COORD_W-1:0] X_ST = COORD_W'(START_H);
    localparam logic [COORD_W-1:0] Y_ST = COORD_W'(START_V);
    localparam logic [COORD_W-1:0] DX   = COORD_W'(STEP_H);
    localparam logic [COORD_W-1:0] DY   = COORD_W'(STEP_V);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(SERVE_DELAY - 1);

    state_t             state, state_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic               conc_right, conc_right_n;
    logic [COORD_W-1:0] x_n, y_n, y_mv;
    logic               dh_n, dv_n, dv_mv;
    logic               hit_n, p1_n, p2_n;
    logic               ovl_left, ovl_right;

    // paddles are judged against the post-move y so corner hits reflect both axes together
    paddle_overlap #(.COORD_W(COORD_W), .SIZE(SIZE), .PADDLE_LEN(PADDLE_LEN)) u_ovl_left (
        .ball_y(y_mv), .paddle(player1_paddle), .overlap(ovl_left)
    );
    paddle_overlap #(.COORD_W(COORD_W), .SIZE(SIZE), .PADDLE_LEN(PADDLE_LEN)) u_ovl_right (
        .ball_y(y_mv), .paddle(player2_paddle), .overlap(ovl_right)
    );

    always_comb begin
        y_mv  = ball_y;
        dv_mv = dir_v;
        if (dir_v == DIR_DOWN) begin
            if (({1'b0, ball_y} + STV_W) >= Y_HI_W) begin
                y_mv  = Y_HI;
                dv_mv = ~DIR_DOWN;
            end else begin
                y_mv = ball_y + DY;
            end
        end else if ({1'b0, ball_y} <= Y_LOE_W) begin
            y_mv  = Y_LO;
            dv_mv = DIR_DOWN;
        end else begin
            y_mv = ball_y - DY;
        end
    end

    always_comb begin
        state_n      = state;
        cnt_n        = cnt;
        conc_right_n = conc_right;
        x_n          = ball_x;
        y_n          = ball_y;
        dh_n         = dir_h;
        dv_n         = dir_v;
        hit_n        = 1'b0;
        p1_n         = 1'b0;
        p2_n         = 1'b0;
        case (state)
            SERVE: if (serve) state_n = PLAY;
            PLAY: if (tick) begin
                y_n  = y_mv;
                dv_n = dv_mv;
                if (dir_h == DIR_RIGHT && ({1'b0, ball_x} + STH_W) >= X_HI_W) begin
                    x_n = X_HI;
                    if (ovl_right) begin
                        dh_n  = ~DIR_RIGHT;
                        hit_n = 1'b1;
                    end else begin
                        p1_n         = 1'b1;
                        state_n      = POINT;
                        cnt_n        = '0;
                        conc_right_n = 1'b1;
                    end
                end else if (dir_h != DIR_RIGHT && {1'b0, ball_x} <= X_LOE_W) begin
                    x_n = X_LO;
                    if (ovl_left) begin
                        dh_n  = DIR_RIGHT;
                        hit_n = 1'b1;
                    end else begin
                        p2_n         = 1'b1;
                        state_n      = POINT;
                        cnt_n        = '0;
                        conc_right_n = 1'b0;
                    end
                end else begin
                    x_n = (dir_h == DIR_RIGHT) ? ball_x + DX : ball_x - DX;
                end
            end
            POINT: if (tick) begin
                if (cnt == CNT_LAST) begin
                    x_n     = X_ST;
                    y_n     = Y_ST;
                    dh_n    = conc_right ? DIR_RIGHT : ~DIR_RIGHT;
                    cnt_n   = '0;
                    state_n = SERVE;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: state_n = SERVE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= SERVE;
            cnt        <= '0;
            conc_right <= 1'b0;
            ball_x     <= X_ST;
            ball_y     <= Y_ST;
            dir_h      <= DIR_RIGHT;
            dir_v      <= DIR_DOWN;
            hit        <= 1'b0;
            p1_point   <= 1'b0;
            p2_point   <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            conc_right <= conc_right_n;
            ball_x     <= x_n;
            ball_y     <= y_n;
            dir_h      <= dh_n;
            dir_v      <= dv_n;
            hit        <= hit_n;
            p1_point   <= p1_n;
            p2_point   <= p2_n;
        end
    end

    assign in_play = (state == PLAY);

endmodule

// File: tb/tb_ball_engine.sv
// Directed and randomized checks of ball_engine against a behavioural playfield model.
module tb_ball_engine;
    localparam int MAX_H = 320, MAX_V = 240, SIZE = 4, PLEN = 32;
    localparam int START_H = 158, START_V = 118, DELAY = 60;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       tick = 1'b0;
    logic       serve = 1'b0;
    logic [8:0] player1_paddle = 9'd100;
    logic [8:0] player2_paddle = 9'd100;
    logic [8:0] ball_x, ball_y;
    logic       dir_h, dir_v, in_play, hit, p1_point, p2_point;

    int total = 0;
    int bad = 0;

    // model: mode 0 waiting for serve, 1 rally, 2 point pause
    int mx, my, mdh, mdv, mmode, mwait, mserve_dir;
    int mhit, mp1, mp2;

    ball_engine dut (
        .clock(clock), .reset(reset), .tick(tick), .serve(serve),
        .player1_paddle(player1_paddle), .player2_paddle(player2_paddle),
        .ball_x(ball_x), .ball_y(ball_y), .dir_h(dir_h), .dir_v(dir_v),
        .in_play(in_play), .hit(hit), .p1_point(p1_point), .p2_point(p2_point)
    );

    always #5 clock = ~clock;

    task automatic chk(string tag, logic [31:0] obs, int exp);
        logic [31:0] e;
        e = exp;
        total++;
        assert (obs === e) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, e);
        end
    endtask

    task automatic model_reset();
        mx = START_H; my = START_V; mdh = 1; mdv = 1;
        mmode = 0; mwait = 0; mserve_dir = 1;
        mhit = 0; mp1 = 0; mp2 = 0;
    endtask

    function automatic bit touches(int y, int p);
        return (y + SIZE > p) && (y < p + PLEN);
    endfunction

    task automatic model_edge(bit t, bit s, int p1, int p2);
        mhit = 0; mp1 = 0; mp2 = 0;
        if (mmode == 0) begin
            if (s) mmode = 1;
        end else if (mmode == 1 && t) begin
            if (mdv == 1) begin
                my = my + 1;
                if (my >= MAX_V - SIZE) begin my = MAX_V - SIZE; mdv = 0; end
            end else if (my <= 1) begin
                my = 0; mdv = 1;
            end else my = my - 1;
            if (mdh == 1 && mx + 1 >= MAX_H - SIZE) begin
                mx = MAX_H - SIZE;
                if (touches(my, p2)) begin mdh = 0; mhit = 1; end
                else begin mp1 = 1; mmode = 2; mwait = DELAY; mserve_dir = 1; end
            end else if (mdh == 0 && mx <= 1) begin
                mx = 0;
                if (touches(my, p1)) begin mdh = 1; mhit = 1; end
                else begin mp2 = 1; mmode = 2; mwait = DELAY; mserve_dir = 0; end
            end else mx = (mdh == 1) ? mx + 1 : mx - 1;
        end else if (mmode == 2 && t) begin
            mwait--;
            if (mwait == 0) begin
                mx = START_H; my = START_V; mdh = mserve_dir; mmode = 0;
            end
        end
    endtask

    task automatic check_all(string ctx);
        chk({ctx, ".ball_x"}, 32'(ball_x), mx);
        chk({ctx, ".ball_y"}, 32'(ball_y), my);
        chk({ctx, ".dir_h"}, 32'(dir_h), mdh);
        chk({ctx, ".dir_v"}, 32'(dir_v), mdv);
        chk({ctx, ".in_play"}, 32'(in_play), (mmode == 1) ? 1 : 0);
        chk({ctx, ".hit"}, 32'(hit), mhit);
        chk({ctx, ".p1_point"}, 32'(p1_point), mp1);
        chk({ctx, ".p2_point"}, 32'(p2_point), mp2);
    endtask

    task automatic cyc(bit t, bit s, string ctx);
        tick = t; serve = s;
        @(posedge clock);
        model_edge(t, s, int'(player1_paddle), int'(player2_paddle));
        #1;
        tick = 1'b0; serve = 1'b0;
        check_all(ctx);
    endtask

    task automatic ticks(int n, string ctx);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, ctx);
    endtask

    task automatic do_reset();
        #2 reset = 1'b0;
        model_reset();
        #1 check_all("reset");
        @(posedge clock); #1;
        reset = 1'b1;
    endtask

    initial begin
        model_reset();
        do_reset();

        ticks(5, "idle");
        chk("idle_x", 32'(ball_x), 158);
        chk("idle_y", 32'(ball_y), 118);

        cyc(1'b1, 1'b1, "serve");
        chk("serve_nomove_x", 32'(ball_x), 158);
        ticks(10, "play10");
        chk("t10_x", 32'(ball_x), 168);
        chk("t10_y", 32'(ball_y), 128);
        chk("t10_in_play", 32'(in_play), 1);

        ticks(108, "play118");
        chk("t118_y", 32'(ball_y), 236);
        chk("t118_dv", 32'(dir_v), 0);
        chk("t118_x", 32'(ball_x), 276);

        player2_paddle = 9'd180;
        ticks(39, "to_paddle");
        cyc(1'b1, 1'b0, "paddle_hit");
        chk("hit_x", 32'(ball_x), 316);
        chk("hit_y", 32'(ball_y), 196);
        chk("hit_pulse", 32'(hit), 1);
        chk("hit_dh", 32'(dir_h), 0);
        cyc(1'b0, 1'b0, "hit_gap");
        chk("hit_one_cycle", 32'(hit), 0);
        cyc(1'b1, 1'b0, "after_hit");
        chk("after_hit_x", 32'(ball_x), 315);

        do_reset();
        player2_paddle = 9'd0;
        cyc(1'b0, 1'b1, "serve2");
        ticks(157, "to_miss");
        cyc(1'b1, 1'b0, "miss");
        chk("miss_p1", 32'(p1_point), 1);
        chk("miss_in_play", 32'(in_play), 0);
        cyc(1'b0, 1'b1, "point_serve_ignored");
        chk("p1_one_cycle", 32'(p1_point), 0);
        ticks(60, "point_wait");
        chk("reserve_x", 32'(ball_x), 158);
        chk("reserve_y", 32'(ball_y), 118);
        chk("reserve_dh", 32'(dir_h), 1);
        chk("reserve_in_play", 32'(in_play), 0);

        // asynchronous reset mid-rally, checked before any clock edge
        cyc(1'b0, 1'b1, "serve3");
        ticks(20, "pre_async");
        #2 reset = 1'b0;
        model_reset();
        #1 check_all("async_reset");
        chk("async_p1", 32'(p1_point), 0);
        @(posedge clock); #1;
        reset = 1'b1;

        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 49) == 0) begin
                player1_paddle = 9'($urandom_range(0, 240));
                player2_paddle = 9'($urandom_range(0, 240));
            end
            cyc(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 7) == 0), "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
